// File: rtl/cronometro_bcd.sv
// cronometro_bcd: BCD stopwatch (00:00..59:59) advanced by rising edges of an async divided clock.
// Optional lap freeze of the displayed digits is enabled with `define CRONO_LAP_EN.
module cronometro_bcd #(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
`ifdef CRONO_LAP_EN
    input  logic       lap,
`endif
    output logic [3:0] sec_u,
    output logic [3:0] sec_t,
    output logic [3:0] min_u,
    output logic [3:0] min_t,
    output logic       running,
    output logic       wrap
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    state_t state;
    logic s1, s2, s3;
    logic [1:0] warm;
    logic [7:0] pre;
    logic [3:0] su, st, mu, mt;
    logic tick_edge, inc, last;
    // warm masks the spurious edge a tick_in already high at reset release would create
    assign tick_edge = s2 & ~s3 & (warm == 2'd3);
    assign inc = (state == RUN) && tick_edge && (pre == 8'(TICKS_PER_SEC - 1));
    assign last = {mt, mu, st, su} == 16'h5959;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
            warm <= 2'd0;
        end else begin
            s1 <= tick_in;
            s2 <= s1;
            s3 <= s2;
            warm <= (warm == 2'd3) ? warm : warm + 2'd1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            running <= 1'b0;
            wrap <= 1'b0;
            pre <= 8'd0;
            {mt, mu, st, su} <= 16'h0000;
        end else if (clear) begin
            state <= IDLE;
            running <= 1'b0;
            wrap <= 1'b0;
            pre <= 8'd0;
            {mt, mu, st, su} <= 16'h0000;
        end else begin
            wrap <= 1'b0;
            if (start_stop) begin
                state <= (state == RUN) ? PAUSE : RUN;
                running <= state != RUN;
            end else if (state == RUN && tick_edge) begin
                pre <= inc ? 8'd0 : pre + 8'd1;
                if (inc) begin
                    su <= (su == 4'd9) ? 4'd0 : su + 4'd1;
                    if (su == 4'd9) begin
                        st <= (st == 4'd5) ? 4'd0 : st + 4'd1;
                        if (st == 4'd5) begin
                            mu <= (mu == 4'd9) ? 4'd0 : mu + 4'd1;
                            if (mu == 4'd9)
                                mt <= (mt == 4'd5) ? 4'd0 : mt + 4'd1;
                        end
                    end
                    wrap <= last;
                end
            end
        end
    end
`ifdef CRONO_LAP_EN
    logic frozen;
    logic [15:0] shadow;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frozen <= 1'b0;
            shadow <= 16'h0000;
        end else if (clear) begin
            frozen <= 1'b0;
        end else if (lap && state == RUN) begin
            frozen <= ~frozen;
            if (!frozen)
                shadow <= {mt, mu, st, su};
        end
    end
    assign {min_t, min_u, sec_t, sec_u} = frozen ? shadow : {mt, mu, st, su};
`else
    assign {min_t, min_u, sec_t, sec_u} = {mt, mu, st, su};
`endif
endmodule
